// File: rtl/lk_tensor_accum.sv
// lk_tensor_accum: serially accumulates the five Lucas-Kanade structure-tensor sums
// over one side x side derivative window, with val/rdy handshakes on both sides.
module lk_tensor_accum #(
   parameter int side = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_val,
   output logic        in_rdy,
   input  logic [31:0] ix [0:side*side-1],
   input  logic [31:0] iy [0:side*side-1],
   input  logic [31:0] it [0:side*side-1],
   output logic        out_val,
   input  logic        out_rdy,
   output logic [31:0] sxx,
   output logic [31:0] sxy,
   output logic [31:0] syy,
   output logic [31:0] sxt,
   output logic [31:0] syt
);
   localparam int N  = side * side;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state, state_nx;
   logic [IW-1:0] idx;
   logic [31:0] lx [0:N-1];
   logic [31:0] ly [0:N-1];
   logic [31:0] lt [0:N-1];
   logic [31:0] px, py, pt;
   logic accept, last;
   // in_rdy is gated by reset so nothing is offered while reset is held
   assign in_rdy  = (state == IDLE) && reset;
   assign out_val = (state == DONE);
   assign accept  = in_val && in_rdy;
   assign last    = (idx == IW'(N - 1));
   assign px = lx[idx];
   assign py = ly[idx];
   assign pt = lt[idx];
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? ACCUM : IDLE;
         ACCUM:   state_nx = last ? DONE : ACCUM;
         DONE:    state_nx = out_rdy ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (accept) begin
         lx <= ix;
         ly <= iy;
         lt <= it;
      end
   // low 32 bits of the product are identical for signed and unsigned operands
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         idx <= '0;
         sxx <= '0;
         sxy <= '0;
         syy <= '0;
         sxt <= '0;
         syt <= '0;
      end else if (accept) begin
         idx <= '0;
         sxx <= '0;
         sxy <= '0;
         syy <= '0;
         sxt <= '0;
         syt <= '0;
      end else if (state == ACCUM) begin
         idx <= last ? '0 : idx + IW'(1);
         sxx <= sxx + px * px;
         sxy <= sxy + px * py;
         syy <= syy + py * py;
         sxt <= sxt + px * pt;
         syt <= syt + py * pt;
      end
endmodule

// File: tb/tb_lk_tensor_accum.sv
// tb_lk_tensor_accum: table of windows with hand-computed sums, scoreboard on output handshakes,
// plus backpressure, reset-abort and streaming sequences.
module tb_lk_tensor_accum;
   localparam int N = 9;
   typedef struct {
      logic [31:0] bx, dx, by, dy, bt, dt;
      logic [31:0] exx, exy, eyy, ext, eyt;
   } vec_t;
   logic clk = 0, reset = 0, in_val = 0, out_rdy = 1;
   logic in_rdy, out_val;
   logic [31:0] ix [0:N-1];
   logic [31:0] iy [0:N-1];
   logic [31:0] it [0:N-1];
   logic [31:0] sxx, sxy, syy, sxt, syt;
   vec_t tv [4];
   int sb [$];
   int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, pop_cyc = 0, mv, p;

   lk_tensor_accum #(.side(3)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
      .ix(ix), .iy(iy), .it(it), .out_val(out_val), .out_rdy(out_rdy),
      .sxx(sxx), .sxy(sxy), .syy(syy), .sxt(sxt), .syt(syt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // scoreboard: every output handshake pops the oldest accepted window
   always @(negedge clk)
      if (out_val && out_rdy) begin
         pop_cyc = cyc;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sxx=%h want none", sxx);
         end else begin
            mv = sb.pop_front();
            chk($sformatf("v%0d sxx", mv), sxx, tv[mv].exx);
            chk($sformatf("v%0d sxy", mv), sxy, tv[mv].exy);
            chk($sformatf("v%0d syy", mv), syy, tv[mv].eyy);
            chk($sformatf("v%0d sxt", mv), sxt, tv[mv].ext);
            chk($sformatf("v%0d syt", mv), syt, tv[mv].eyt);
         end
      end

   task automatic drive(input int v);
      for (int k = 0; k < N; k++) begin
         ix[k] = tv[v].bx + tv[v].dx * 32'(k);
         iy[k] = tv[v].by + tv[v].dy * 32'(k);
         it[k] = tv[v].bt + tv[v].dt * 32'(k);
      end
   endtask

   task automatic send(input int v, input bit keep);
      int n;
      drive(v);
      in_val = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_rdy && n < 50);
      chk("accept", {31'b0, in_rdy}, 1);
      if (in_rdy) begin
         sb.push_back(v);
         acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (!keep) in_val = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_val && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      tv[0] = '{32'd1, 32'd0, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0,
                32'd9, 32'd18, 32'd36, 32'hFFFFFFF7, 32'hFFFFFFEE};
      tv[1] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1,
                32'd204, 32'd36, 32'd9, 32'd240, 32'd45};
      tv[2] = '{32'h00010000, 32'd0, 32'h00008000, 32'd0, 32'd0, 32'd0,
                32'd0, 32'h80000000, 32'h40000000, 32'd0, 32'd0};
      tv[3] = '{32'hFFFFFFFD, 32'd2, 32'd5, 32'hFFFFFFFF, 32'd7, 32'd0,
                32'd465, 32'hFFFFFFB5, 32'd69, 32'd315, 32'd63};
      drive(0);
      in_val = 1;
      repeat (2) @(negedge clk);
      chk("reset in_rdy", {31'b0, in_rdy}, 0);
      chk("reset out_val", {31'b0, out_val}, 0);
      chk("reset sxx", sxx, 0);
      chk("reset syt", syt, 0);
      @(posedge clk);
      #1 reset = 1;
      for (int i = 0; i < 4; i++) begin
         send(i, 0);
         if (i == 0) begin
            wait_out();
            chk("latency", 32'(cyc - acc_cyc), 10);
         end
         drain();
      end
      // backpressure with a competing window that must be ignored
      out_rdy = 0;
      send(1, 0);
      wait_out();
      drive(3);
      in_val = 1;
      repeat (20) begin
         chk("bp out_val", {31'b0, out_val}, 1);
         chk("bp in_rdy", {31'b0, in_rdy}, 0);
         chk("bp sxx", sxx, tv[1].exx);
         chk("bp syt", syt, tv[1].eyt);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_rdy = 1;
      send(3, 0);
      chk("reaccept gap", 32'(acc_cyc - pop_cyc), 1);
      drain();
      // reset four cycles into ACCUM
      send(0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 0;
      #1;
      chk("midrst out_val", {31'b0, out_val}, 0);
      chk("midrst in_rdy", {31'b0, in_rdy}, 0);
      chk("midrst sxx", sxx, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1;
      repeat (12) @(negedge clk);
      chk("no stale out_val", {31'b0, out_val}, 0);
      @(posedge clk);
      #1;
      send(0, 0);
      drain();
      // back-to-back streaming
      send(3, 1);
      p = acc_cyc;
      send(1, 1);
      chk("stream gap 1", 32'(acc_cyc - p), 11);
      p = acc_cyc;
      send(0, 0);
      chk("stream gap 2", 32'(acc_cyc - p), 11);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end
endmodule
